// File: rtl/mag_env_detect.sv
// Peak-hold envelope detector for the magnitude stream: instant attack, sample-counted hold,
// then exponential decay by env >> DSH, floored at the current input.
module mag_env_detect #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned DSH  = 2,
    parameter int unsigned HW   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] m,
    input  logic        iv,
    input  logic        clr,
    output logic [15:0] env,
    output logic        ov,
    output logic [1:0]  st
);

    localparam int unsigned MW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_e;

    state_e          st_q, st_d;
    logic [MW-1:0]   env_q, env_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            ov_q, ov_d;

    logic [MW-1:0]   step_c;
    logic [MW-1:0]   dec_c;
    logic [MW-1:0]   floor_c;

    // Decay step is at least 1 so the envelope always drains to zero; step <= env, so no underflow.
    always_comb begin
        step_c = env_q >> DSH;
        if (step_c == '0) begin
            step_c = MW'(1);
        end
        dec_c   = env_q - step_c;
        floor_c = (dec_c > m) ? dec_c : m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            env_q  <= '0;
            hcnt_q <= '0;
            ov_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            env_q  <= env_d;
            hcnt_q <= hcnt_d;
            ov_q   <= ov_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        env_d  = env_q;
        hcnt_d = hcnt_q;
        ov_d   = 1'b0;

        if (clr) begin
            st_d   = ST_IDLE;
            env_d  = '0;
            hcnt_d = '0;
        end else if (iv) begin
            ov_d = 1'b1;
            if (m >= env_q) begin
                // Attack; an all-zero sample on an empty envelope stays idle.
                env_d = m;
                if (m == '0) begin
                    st_d   = ST_IDLE;
                    hcnt_d = '0;
                end else begin
                    st_d   = ST_HOLD;
                    hcnt_d = HW'(HOLD);
                end
            end else begin
                case (st_q)
                    ST_HOLD: begin
                        if (hcnt_q > HW'(1)) begin
                            hcnt_d = hcnt_q - HW'(1);
                        end else begin
                            hcnt_d = '0;
                            st_d   = ST_DECAY;
                        end
                    end
                    ST_DECAY: begin
                        env_d = floor_c;
                        if (floor_c == '0) begin
                            st_d = ST_IDLE;
                        end
                    end
                    default: begin
                        st_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign env = env_q;
    assign ov  = ov_q;
    assign st  = st_q;

endmodule

// File: tb/tb_mag_env_detect.sv
// Self-checking bench for mag_env_detect: directed scenarios plus randomized traffic vs. a reference model.
module tb_mag_env_detect;

    localparam int unsigned HOLD = 4;
    localparam int unsigned DSH  = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] m;
    logic        iv;
    logic        clr;
    logic [15:0] env;
    logic        ov;
    logic [1:0]  st;

    int checks;
    int errors;

    // Reference model state (plain integers)
    int env_m;
    int st_m;
    int hold_m;
    int ov_m;

    mag_env_detect #(.HOLD(HOLD), .DSH(DSH), .HW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m     (m),
        .iv    (iv),
        .clr   (clr),
        .env   (env),
        .ov    (ov),
        .st    (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs and return 1 time unit after the capturing edge.
    task automatic drive(input int mv, input logic ivv, input logic clrv);
        @(negedge clk);
        m   = 16'(mv);
        iv  = ivv;
        clr = clrv;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        env_m  = 0;
        st_m   = 0;
        hold_m = 0;
        ov_m   = 0;
    endtask

    task automatic model_apply(input int mv, input logic ivv, input logic clrv);
        int step;
        int d;
        if (clrv) begin
            model_reset();
        end else if (ivv) begin
            ov_m = 1;
            if (mv >= env_m) begin
                env_m = mv;
                if (mv == 0) begin
                    st_m   = 0;
                    hold_m = 0;
                end else begin
                    st_m   = 1;
                    hold_m = HOLD;
                end
            end else if (st_m == 1) begin
                hold_m = hold_m - 1;
                if (hold_m == 0) st_m = 2;
            end else if (st_m == 2) begin
                step = env_m / (1 << DSH);
                if (step == 0) step = 1;
                d = env_m - step;
                env_m = (d > mv) ? d : mv;
                if (env_m == 0) st_m = 0;
            end
        end else begin
            ov_m = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m = '0; iv = 1'b0; clr = 1'b0;
        #12;
        checks++;
        if (env !== 16'd0 || ov !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL reset: env=%0d ov=%0b st=%0d, want env=0 ov=0 st=0", env, ov, st);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_attack_hold();
        int exp_env [10];
        int exp_st  [10];
        exp_env = '{10000, 10000, 10000, 10000, 10000, 7500, 5625, 0, 0, 0};
        exp_st  = '{1, 1, 1, 1, 2, 2, 2, 0, 0, 0};
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive((i == 0) ? 10000 : 0, 1'b1, 1'b0);
            checks++;
            if (ov !== 1'b1 || env !== 16'(exp_env[i]) || st !== 2'(exp_st[i])) begin
                errors++;
                $display("FAIL attack_hold[%0d]: ov=%0b env=%0d st=%0d, want ov=1 env=%0d st=%0d",
                         i, ov, env, st, exp_env[i], exp_st[i]);
            end
        end
        drive(0, 1'b0, 1'b0);
        checks++;
        if (ov !== 1'b0 || env !== 16'd5625 || st !== 2'd2) begin
            errors++;
            $display("FAIL idle_hold: ov=%0b env=%0d st=%0d, want ov=0 env=5625 st=2", ov, env, st);
        end
    endtask

    task automatic test_tail();
        int exp_env [4];
        int exp_st  [4];
        exp_env = '{2, 1, 0, 0};
        exp_st  = '{2, 2, 0, 0};
        drive(0, 1'b0, 1'b1);
        drive(3, 1'b1, 1'b0);
        for (int i = 0; i < HOLD; i++) drive(0, 1'b1, 1'b0);
        checks++;
        if (env !== 16'd3 || st !== 2'd2) begin
            errors++;
            $display("FAIL tail_setup: env=%0d st=%0d, want env=3 st=2", env, st);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b0);
            checks++;
            if (env !== 16'(exp_env[i]) || st !== 2'(exp_st[i]) || ov !== 1'b1) begin
                errors++;
                $display("FAIL tail[%0d]: env=%0d st=%0d ov=%0b, want env=%0d st=%0d ov=1",
                         i, env, st, ov, exp_env[i], exp_st[i]);
            end
        end
    endtask

    task automatic test_reattack_floor();
        drive(0, 1'b0, 1'b1);
        drive(10000, 1'b1, 1'b0);
        for (int i = 0; i < HOLD + 2; i++) drive(0, 1'b1, 1'b0);
        drive(7071, 1'b1, 1'b0);
        checks++;
        if (env !== 16'd7071 || st !== 2'd1) begin
            errors++;
            $display("FAIL reattack: env=%0d st=%0d, want env=7071 st=1", env, st);
        end
        for (int i = 0; i < HOLD; i++) begin
            drive(0, 1'b1, 1'b0);
            checks++;
            if (env !== 16'd7071 || st !== ((i == HOLD - 1) ? 2'd2 : 2'd1)) begin
                errors++;
                $display("FAIL rehold[%0d]: env=%0d st=%0d, want env=7071 st=%0d",
                         i, env, st, (i == HOLD - 1) ? 2 : 1);
            end
        end
        drive(0, 1'b0, 1'b1);
        drive(10000, 1'b1, 1'b0);
        for (int i = 0; i < HOLD + 1; i++) drive(0, 1'b1, 1'b0);
        drive(7000, 1'b1, 1'b0);
        checks++;
        if (env !== 16'd7000 || st !== 2'd2) begin
            errors++;
            $display("FAIL floor: env=%0d st=%0d, want env=7000 st=2", env, st);
        end
    endtask

    task automatic test_back_to_back();
        int ms      [8];
        int exp_env [8];
        ms      = '{3000, 4000, 5000, 0, 0, 0, 0, 0};
        exp_env = '{3000, 4000, 5000, 5000, 5000, 5000, 5000, 3750};
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(ms[i], 1'b1, 1'b0);
            checks++;
            if (ov !== 1'b1 || env !== 16'(exp_env[i])) begin
                errors++;
                $display("FAIL b2b[%0d]: ov=%0b env=%0d, want ov=1 env=%0d", i, ov, env, exp_env[i]);
            end
        end
        drive(0, 1'b0, 1'b0);
        checks++;
        if (ov !== 1'b0 || env !== 16'd3750) begin
            errors++;
            $display("FAIL b2b_end: ov=%0b env=%0d, want ov=0 env=3750", ov, env);
        end
    endtask

    task automatic test_clr_collision();
        drive(0, 1'b0, 1'b1);
        drive(500, 1'b1, 1'b0);
        drive(10000, 1'b1, 1'b1);
        checks++;
        if (env !== 16'd0 || ov !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL clr_collision: env=%0d ov=%0b st=%0d, want env=0 ov=0 st=0", env, ov, st);
        end
        drive(1000, 1'b1, 1'b0);
        checks++;
        if (env !== 16'd1000 || ov !== 1'b1 || st !== 2'd1) begin
            errors++;
            $display("FAIL clr_after: env=%0d ov=%0b st=%0d, want env=1000 ov=1 st=1", env, ov, st);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1'b0, 1'b1);
        drive(10000, 1'b1, 1'b0);
        @(negedge clk);
        iv = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (env !== 16'd0 || ov !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: env=%0d ov=%0b st=%0d, want env=0 ov=0 st=0", env, ov, st);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int   mv;
        logic ivv;
        logic clrv;
        int   sel;
        drive(0, 1'b0, 1'b1);
        model_reset();
        for (int i = 0; i < 600; i++) begin
            ivv  = ($urandom_range(0, 9) < 7);
            clrv = ($urandom_range(0, 99) == 0);
            sel  = $urandom_range(0, 9);
            if (sel < 4)       mv = 0;
            else if (sel < 6)  mv = $urandom_range(0, 15);
            else if (sel < 8)  mv = $urandom_range(0, 4000);
            else               mv = $urandom_range(0, 65535);
            drive(mv, ivv, clrv);
            model_apply(mv, ivv, clrv);
            checks++;
            if (ov !== 1'(ov_m) || env !== 16'(env_m) || st !== 2'(st_m)) begin
                errors++;
                $display("FAIL random[%0d]: ov=%0b env=%0d st=%0d, want ov=%0d env=%0d st=%0d",
                         i, ov, env, st, ov_m, env_m, st_m);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_attack_hold();
        test_tail();
        test_reattack_floor();
        test_back_to_back();
        test_clr_collision();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mag_env_detect.md
Name: mag_env_detect

Overview:
- Envelope detector that consumes the magnitude stream produced by the 16-bit magnitude calculator (m / ov strobe) and produces a peak-hold envelope for AGC and S-meter use.
- Three modes of behaviour:
  - Instant attack.
  - Programmable hold period, counted in samples.
  - Exponential decay by a fixed right shift.
- Sits directly downstream of the magnitude stage. Its output strobe drives the AGC gain computation.

Parameters:
- HOLD, 4: number of valid samples the envelope is held after an attack (minimum 1; 0 is illegal).
- DSH, 2: decay shift; per-sample decay step is env >> DSH (range 1..15).
- HW, 8: hold-counter width in bits; must satisfy HOLD < 2^HW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m  in  16  unsigned magnitude sample.
- iv  in  1  input valid strobe, one cycle per sample; may be high on consecutive cycles.
- clr  in  1  synchronous clear of envelope and state.
- env  out  16  unsigned envelope, registered.
- ov  out  1  output valid, 1-cycle pulse.
- st  out  2  state: 0=IDLE, 1=HOLD, 2=DECAY.

Behaviour:
- Reset (rst_n low, asynchronous):
  - env=0, ov=0, st=IDLE, hold counter=0.
  - Reset mid-operation discards all state immediately.
- clr=1 on a rising edge:
  - Same values as reset.
  - Overrides iv in the same cycle; no ov is generated for that sample.
- Latency: ov=1 exactly one cycle after each iv=1 cycle.
  - env is valid while ov=1 and holds its value until the next update.
  - Back-to-back iv (every cycle) is fully supported, with no stalls.
- iv=0 and clr=0: env, st and hold counter are unchanged; ov=0.
- Per valid sample (iv=1), evaluated in priority order:
  1. Attack, m >= env (in any state): env<=m, hcnt<=HOLD, st<=HOLD. The m==env case restarts the hold. If m=0 and env=0, st<=IDLE instead.
  2. st=HOLD, m<env:
     - If hcnt>1: hcnt<=hcnt-1, env unchanged.
     - If hcnt==1: hcnt<=0, st<=DECAY, env unchanged.
     - Net effect: exactly HOLD non-attack samples leave env unchanged after an attack.
  3. st=DECAY, m<env:
     - step = env>>DSH; if step==0, step=1, so env always reaches 0.
     - d = env-step, computed without underflow since step <= env.
     - env <= max(d, m): the envelope never falls below the current input.
     - If the new env==0, st<=IDLE; otherwise st stays DECAY.
  4. st=IDLE with m>0 is covered by attack (1), since env=0.
- Arithmetic: all values are unsigned 16-bit; no saturation is needed because env never exceeds the max m seen.
- st is a direct registered copy of the state register; the encoding 3 is unreachable and decodes to IDLE on the next valid sample.

Test Plan:
- Reset: assert rst_n=0 mid-stream with env=10000 -> env=0, ov=0, st=0 immediately, without waiting for a clock.
- Attack + hold (HOLD=4, DSH=2): one sample m=10000 -> next cycle ov=1, env=10000, st=1. Then four samples m=0 -> env stays 10000, st=2 after the 4th. 5th sample -> env=7500; 6th -> env=5625.
- Tail to zero: in DECAY with env=3, feed m=0 samples -> env 2, 1, 0, with st=0 after the last. A further m=0 sample -> env=0, st=0.
- Re-attack and floor:
  - In DECAY at env=5625, m=7071 -> env=7071, st=1, hold restarts (4 samples).
  - In DECAY at env=7500, m=7000 -> env=7000 (floor), st=2.
- Back-to-back: iv high for 8 consecutive cycles with m=3000,4000,5000,0,0,0,0,0 -> ov high 8 consecutive cycles, delayed one cycle. env = 3000, 4000, 5000, then 5000 x4, then 3750.
- clr collision: clr=1 and iv=1 (m=10000) on the same edge -> env=0, ov=0, st=0. The next iv with m=1000 -> env=1000, st=1.
